// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined two-level carry-lookahead adder/subtractor with valid/ready
//   handshaking on both sides. Bit generate/propagate feed a first lookahead
//   level over GROUP-bit groups and a second lookahead level across groups.
//   Results are registered over STAGES slices (1..3). The slices are split as
//   bit g/p | group lookahead | sum/flags, and fewer stages collapse the
//   earlier cuts first.
//
// Parameters
//   WIDTH  : operand width (multiple of GROUP, at least GROUP)
//   GROUP  : bits per first-level lookahead group
//   STAGES : pipeline depth and latency in cycles (1..3)
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operands present
//   in_ready   : operands accepted this cycle (== pipeline advance)
//   a, b       : operands
//   ci         : carry-in (add mode only)
//   sub        : 1 = a - b
//   out_valid  : result present
//   out_ready  : consumer takes result
//   sum        : result modulo 2^WIDTH
//   co         : carry-out of MSB (sub: 1 = no borrow)
//   ovf        : signed overflow
//   zero       : sum == 0
//
// Build option
//   CLA_PIPE_FLAGS_EN : when defined, ovf and zero are computed and pipelined;
//                       otherwise both are tied to 0 and their logic removed.

module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP;

    // One global enable: the whole pipeline moves together, so bubbles keep
    // their positions and in_ready is the only combinational input path.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Bit-level generate/propagate; subtraction is a + ~b + 1.
    logic [WIDTH-1:0] b_x, g_bit, p_bit;
    logic             c_in;
    assign b_x   = sub ? ~b : b;
    assign g_bit = a & b_x;
    assign p_bit = a ^ b_x;
    assign c_in  = sub | ci;

    logic [WIDTH-1:0] g_la, p_la;
    logic             c_la, v_la;

    // Slice after bit g/p exists only in the three-stage build.
    generate
        if (STAGES >= 3) begin : g_slice_gp
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_la <= 1'b0;
                    g_la <= '0;
                    p_la <= '0;
                    c_la <= 1'b0;
                end else if (adv) begin
                    v_la <= in_valid;
                    g_la <= g_bit;
                    p_la <= p_bit;
                    c_la <= c_in;
                end
            end
        end else begin : g_pass_gp
            assign v_la = in_valid;
            assign g_la = g_bit;
            assign p_la = p_bit;
            assign c_la = c_in;
        end
    endgenerate

    // Two-level lookahead. Every carry is a sum-of-products of g/p terms and
    // a single carry source (c_la for groups, the group carry-in for bits);
    // no carry is derived from its neighbour, so nothing ripples.
    logic [NG-1:0]  grp_g, grp_p;
    logic [NG:0]    grp_c;
    logic [WIDTH:0] c;
    logic           run, acc;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        run   = 1'b0;
        acc   = 1'b0;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int k = GROUP - 1; k >= 0; k--) begin
                acc = acc | (g_la[j*GROUP+k] & run);
                run = run & p_la[j*GROUP+k];
            end
            grp_g[j] = acc;
            grp_p[j] = run;
        end
        grp_c[0] = c_la;
        for (int j = 0; j < NG; j++) begin
            acc = 1'b0;
            run = 1'b1;
            for (int k = NG - 1; k >= 0; k--) begin
                if (k <= j) begin
                    acc = acc | (grp_g[k] & run);
                    run = run & grp_p[k];
                end
            end
            grp_c[j+1] = acc | (run & c_la);
        end
        for (int j = 0; j < NG; j++) begin
            c[j*GROUP] = grp_c[j];
            for (int i = 1; i < GROUP; i++) begin
                acc = 1'b0;
                run = 1'b1;
                for (int k = GROUP - 1; k >= 0; k--) begin
                    if (k < i) begin
                        acc = acc | (g_la[j*GROUP+k] & run);
                        run = run & p_la[j*GROUP+k];
                    end
                end
                c[j*GROUP+i] = acc | (run & grp_c[j]);
            end
        end
        c[WIDTH] = grp_c[NG];
    end

    logic [WIDTH-1:0] sum_la;
    logic             co_la;
    assign sum_la = p_la ^ c[WIDTH-1:0];
    assign co_la  = c[WIDTH];

    logic [WIDTH-1:0] sum_fl;
    logic             co_fl, v_fl;
`ifdef CLA_PIPE_FLAGS_EN
    logic ovf_la, ovf_fl, zero_fl;
    assign ovf_la = c[WIDTH] ^ c[WIDTH-1];
`endif

    // Slice after group lookahead exists for two or more stages.
    generate
        if (STAGES >= 2) begin : g_slice_la
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_fl   <= 1'b0;
                    sum_fl <= '0;
                    co_fl  <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
                    ovf_fl <= 1'b0;
`endif
                end else if (adv) begin
                    v_fl   <= v_la;
                    sum_fl <= sum_la;
                    co_fl  <= co_la;
`ifdef CLA_PIPE_FLAGS_EN
                    ovf_fl <= ovf_la;
`endif
                end
            end
        end else begin : g_pass_la
            assign v_fl   = v_la;
            assign sum_fl = sum_la;
            assign co_fl  = co_la;
`ifdef CLA_PIPE_FLAGS_EN
            assign ovf_fl = ovf_la;
`endif
        end
    endgenerate

`ifdef CLA_PIPE_FLAGS_EN
    assign zero_fl = ~|sum_fl;
    logic ovf_q, zero_q;
`endif

    // Output slice is always present; it is what the consumer sees and holds
    // steady while out_ready is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= v_fl;
            sum       <= sum_fl;
            co        <= co_fl;
`ifdef CLA_PIPE_FLAGS_EN
            ovf_q     <= ovf_fl;
            zero_q    <= zero_fl;
`endif
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined two-level carry-lookahead adder/subtractor with valid/ready handshaking on both sides. Successor to the single-level lookahead component: computes per-bit generate/propagate, group lookahead (GROUP bits), and a second lookahead level across groups, with results registered over STAGES pipeline stages. It sits between operand registers and the ALU result mux and replaces ripple or single-level carry chains wherever a 32-bit or wider add is needed at full clock rate.

## Interface
- WIDTH, 32, operand width; must be a multiple of GROUP, minimum GROUP.
- GROUP, 4, bits per first-level lookahead group.
- STAGES, 2, pipeline depth, legal 1..3; equals latency in cycles.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in, add mode only.
- sub  in  1  1 = a - b (b inverted, carry-in forced to 1, ci ignored).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- co  out  1  carry-out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Bit level: g[i] = a[i] & b'[i], p[i] = a[i] ^ b'[i], b' = sub ? ~b : b, c0 = sub ? 1 : ci.
- Group level: per group, group G/P prefix computed as in the single-level component; group carry-in from second-level lookahead over WIDTH/GROUP groups; sum[i] = p[i] ^ c[i].
- All carries come from explicit g/p lookahead; no behavioural `+` in the datapath.
- ovf = c[WIDTH] ^ c[WIDTH-1]; co = c[WIDTH].
- Pipeline: STAGES register slices, each holding a valid bit plus partial results; stage split: bit g/p | group lookahead | sum/flags, collapsed in order for smaller STAGES. Results must be bit-identical for every STAGES value.
- Flow control: global enable adv = !out_valid | out_ready. When adv = 1 all stages shift; when 0 all hold. in_ready = adv.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Bubbles (invalid stages) travel with the pipeline; they are not collapsed.
- Outputs sum/co/ovf/zero are meaningful only when out_valid = 1; they hold while out_valid & !out_ready.

## Timing
- Reset: all stage valid bits 0; out_valid = 0, sum = 0, co = 0, ovf = 0, zero = 0; in_ready = 1 during and after reset (out_valid = 0).
- Latency: operand accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, i.e. sampled at edge N+STAGES, provided adv stayed 1.
- Throughput: one operation per cycle with out_ready held 1.
- Stall: out_ready = 0 with out_valid = 1 drops in_ready combinationally in the same cycle; no operand is lost or duplicated.
- Simultaneous accept and emit with full pipeline and out_ready = 1: both transfers occur in the same cycle.
- Reset mid-operation: all in-flight operations discarded; first cycle after rst deassertion behaves as post-reset.
- in_ready depends combinationally on out_ready; no other input-to-output combinational path.

## Configuration
- CLA_PIPE_FLAGS_EN defined: ovf and zero computed and pipelined as above.
- Not defined: ovf and zero tied to 0, their flag logic and registers removed; sum, co and handshake unchanged.

## Test plan
- Reset then add: WIDTH=32, STAGES=2, a=0xFFFFFFFF, b=0x00000001, ci=0 -> 2 cycles later sum=0x00000000, co=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, ovf=1, co=0; sub case a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, co=1.
- Back-to-back stream of 100 random operands with out_ready=1 -> 100 results in order, one per cycle, matching reference model.
- Backpressure: pipeline full, out_ready=0 for 5 cycles -> in_ready=0, outputs held stable; release -> results resume in order, no loss or duplication.
- Reset mid-stream: 2 ops in flight, rst pulsed 1 cycle -> out_valid=0 next cycle, no stale results ever emitted.
- Sweep STAGES 1/2/3 and WIDTH 8/32/64 (GROUP=4) with identical random stimulus -> identical result sequences, latency equal to STAGES.
